instr_fetch_responder: RTL and testbench

- Memory-side responder for the fetch stage's instruction port.
- Fetch drives a 64-bit address every cycle and samples the 64-bit instruction word at the next posedge while not stalled.
- This block answers from a small direct-mapped buffer of 64-bit instruction words. On a miss it raises stall and refills the entry over a 32-bit req/ack backing bus, two beats per word.

---
 rtl/fetch_mem_pkg.sv | 21 ++
 rtl/instr_fetch_responder_if.sv | 24 ++
 rtl/instr_line_buffer.sv | 53 +++++
 rtl/opcodes.sv | 4 +
 rtl/instr_fetch_responder.sv | 134 +++++++++++++
 tb/tb_instr_fetch_responder.sv | 221 ++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_mem_pkg.sv
// Types and widths shared by the instruction fetch responder and its line buffer.
`ifndef INSTR_NOP
`define INSTR_NOP 64'h0000_0000_0000_0013
`endif

package fetch_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2
  } fetch_state_e;

  localparam int ADDR_W  = 64;
  localparam int WORD_W  = 61;
  localparam int INSTR_W = 64;
  localparam int BEAT_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = `INSTR_NOP;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch port plus 32-bit backing bus; slave is the responder, master is fetch/memory.
interface instr_fetch_responder_if;
  import fetch_mem_pkg::*;

  logic               instr_read_in;
  logic [ADDR_W-1:0]  instr_address_in;
  logic [INSTR_W-1:0] instr_read_value_out;
  logic               stall_out;
  logic               invalidate_in;
  logic               mem_req_out;
  logic [ADDR_W-1:0]  mem_addr_out;
  logic               mem_ack_in;
  logic [BEAT_W-1:0]  mem_rdata_in;

  modport slave (
    input  instr_read_in, instr_address_in, invalidate_in, mem_ack_in, mem_rdata_in,
    output instr_read_value_out, stall_out, mem_req_out, mem_addr_out
  );

  modport master (
    output instr_read_in, instr_address_in, invalidate_in, mem_ack_in, mem_rdata_in,
    input  instr_read_value_out, stall_out, mem_req_out, mem_addr_out
  );
endinterface

// File: rtl/instr_line_buffer.sv
// Direct-mapped storage of valid/tag/data per entry; combinational read, synchronous write and clear.
module instr_line_buffer
  import fetch_mem_pkg::*;
#(
  parameter int LINES   = 4,
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [INSTR_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic               i_wr_set_valid,
  input  logic               i_clear_all
);

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [INSTR_W-1:0] r_data [LINES];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

  // Valid bits: a write landing with a clear keeps the later set_valid, which is low then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clear_all) begin
        r_valid <= '0;
      end
      if (i_wr_en) begin
        r_valid[i_wr_index] <= i_wr_set_valid;
      end
    end
  end

  // Tag and data storage, meaningful only behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

endmodule

// File: rtl/opcodes.sv
// Shared instruction encodings used by fetch-side blocks.
`ifndef INSTR_NOP
`define INSTR_NOP 64'h0000_0000_0000_0013
`endif

// File: rtl/instr_fetch_responder.sv
// Answers fetch from the line buffer; on a miss stalls and refills the word over two 32-bit beats.
module instr_fetch_responder
  import fetch_mem_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instr_fetch_responder_if.slave  bus
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = WORD_W - INDEX_W;

  fetch_state_e        r_state;
  logic [WORD_W-1:0]   r_word;
  logic [BEAT_W-1:0]   r_lo;
  logic                r_drop;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [WORD_W-1:0]   w_word;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [INSTR_W-1:0]  w_rd_data;
  logic                w_hit;
  logic                w_wr_en;
  logic                w_set_valid;
  logic [INSTR_W-1:0]  w_value;
  logic                w_stall;
  logic                w_unused;

  assign w_word   = bus.instr_address_in[63:3];
  assign w_index  = w_word[INDEX_W-1:0];
  assign w_tag    = w_word[WORD_W-1:INDEX_W];
  assign w_unused = ^bus.instr_address_in[2:0];

  assign w_hit = (r_state == IDLE) & bus.instr_read_in & w_rd_valid
               & (w_rd_tag == w_tag) & !bus.invalidate_in;

  // An invalidate seen anywhere in the fill, including the final beat, leaves the entry invalid.
  assign w_wr_en     = (r_state == FETCH_HI) & bus.mem_ack_in;
  assign w_set_valid = !r_drop & !bus.invalidate_in;

  instr_line_buffer #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_line_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_index     (w_index),
    .o_rd_valid     (w_rd_valid),
    .o_rd_tag       (w_rd_tag),
    .o_rd_data      (w_rd_data),
    .i_wr_en        (w_wr_en),
    .i_wr_index     (r_word[INDEX_W-1:0]),
    .i_wr_tag       (r_word[WORD_W-1:INDEX_W]),
    .i_wr_data      ({bus.mem_rdata_in, r_lo}),
    .i_wr_set_valid (w_set_valid),
    .i_clear_all    (bus.invalidate_in)
  );

  // Fetch-side answer: entry data on a hit, otherwise NOP with stall while a read is pending.
  always_comb begin
    w_value = NOP_WORD;
    w_stall = 1'b0;
    if (!rst_n) begin
      w_value = NOP_WORD;
      w_stall = 1'b1;
    end else if (w_hit) begin
      w_value = w_rd_data;
      w_stall = 1'b0;
    end else begin
      w_value = NOP_WORD;
      w_stall = bus.instr_read_in;
    end
  end

  assign bus.instr_read_value_out = w_value;
  assign bus.stall_out            = w_stall;
  assign bus.mem_req_out          = r_mem_req;
  assign bus.mem_addr_out         = r_mem_addr;

  // Refill sequencer; a reset mid-fill simply drops the outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_lo       <= '0;
      r_drop     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instr_read_in && !w_hit && !bus.invalidate_in) begin
            r_word     <= w_word;
            r_drop     <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_word, 3'b000};
            r_state    <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (bus.invalidate_in) begin
            r_drop <= 1'b1;
          end
          if (bus.mem_ack_in) begin
            r_lo       <= bus.mem_rdata_in;
            r_mem_addr <= r_mem_addr + 64'd4;
            r_state    <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (bus.invalidate_in) begin
            r_drop <= 1'b1;
          end
          if (bus.mem_ack_in) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench: memory responder model with programmable ack delay and an expected-word scoreboard.
module tb_instr_fetch_responder;
  import fetch_mem_pkg::*;

  logic clk;
  logic rst_n;

  instr_fetch_responder_if bus ();

  instr_fetch_responder #(.LINES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int unstable = 0;
  bit prev_wait = 1'b0;
  logic [63:0] prev_addr = 64'd0;
  logic [63:0] acked[$];
  logic [63:0] sb[$];

  // Backing memory contents: the word at 0x1000 is a NOP, everything else is address-derived.
  function automatic logic [31:0] beat(input logic [63:0] a);
    if (a == 64'h1000) return 32'h0000_0013;
    else if (a == 64'h1004) return 32'h0000_0000;
    else return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    return {beat(base + 64'd4), beat(base)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay idle cycles per beat, and watches req/addr stability.
  always begin
    @(posedge clk);
    #1;
    if (bus.mem_req_out && rst_n) begin
      if (prev_wait && (bus.mem_addr_out !== prev_addr)) unstable++;
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack_in   = 1'b1;
        bus.mem_rdata_in = beat(bus.mem_addr_out);
        acked.push_back(bus.mem_addr_out);
        wait_cnt  = 0;
        prev_wait = 1'b0;
      end else begin
        bus.mem_ack_in = 1'b0;
        wait_cnt++;
        prev_wait = 1'b1;
        prev_addr = bus.mem_addr_out;
      end
    end else begin
      if (prev_wait && rst_n) unstable++;
      bus.mem_ack_in = 1'b0;
      wait_cnt  = 0;
      prev_wait = 1'b0;
    end
  end

  // Issue one read and hold it until the word arrives; compares word and stall-cycle count.
  task automatic fetch(input logic [63:0] a, input int exp_stalls, input string tag);
    int stalls;
    bit done;
    logic [63:0] exp;
    stalls = 0;
    done = 1'b0;
    sb.push_back(model_word(a));
    bus.instr_address_in = a;
    bus.instr_read_in = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.stall_out) begin
        stalls++;
      end else begin
        exp = sb.pop_front();
        check({tag, "_word"}, bus.instr_read_value_out, exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check({tag, "_timeout"}, 64'd1, 64'd0);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    bus.instr_read_in = 1'b0;
  endtask

  // Start a fill and pulse invalidate on the given cycle of it (1 = low-beat ack, 2 = high-beat ack).
  task automatic fill_with_inv(input logic [63:0] a, input int inv_cycle, input string tag);
    bit idle;
    bus.instr_address_in = a;
    bus.instr_read_in = 1'b1;
    repeat (inv_cycle) begin
      @(posedge clk);
      #1;
    end
    bus.invalidate_in = 1'b1;
    @(negedge clk);
    check({tag, "_inv_stall"}, {63'd0, bus.stall_out}, 64'd1);
    check({tag, "_inv_nop"}, bus.instr_read_value_out, NOP_WORD);
    @(posedge clk);
    #1;
    bus.invalidate_in = 1'b0;
    bus.instr_read_in = 1'b0;
    idle = 1'b0;
    for (int c = 0; c < 32 && !idle; c++) begin
      if (!bus.mem_req_out) idle = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_fill_done"}, {63'd0, idle}, 64'd1);
  endtask

  initial begin
    int u0;
    rst_n = 1'b0;
    bus.instr_read_in = 1'b0;
    bus.instr_address_in = 64'd0;
    bus.invalidate_in = 1'b0;
    bus.mem_ack_in = 1'b0;
    bus.mem_rdata_in = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst_stall", {63'd0, bus.stall_out}, 64'd1);
    check("rst_nop", bus.instr_read_value_out, NOP_WORD);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req", {63'd0, bus.mem_req_out}, 64'd0);
    check("rst_addr", bus.mem_addr_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stall", {63'd0, bus.stall_out}, 64'd0);
    check("idle_nop", bus.instr_read_value_out, NOP_WORD);
    @(posedge clk);
    #1;

    // 1: cold miss on 0x1000
    acked.delete();
    fetch(64'h1000, 3, "t1");
    check("t1_word_const", model_word(64'h1000), 64'h0000_0000_0000_0013);
    check("t1_nbeats", 64'(acked.size()), 64'd2);
    check("t1_addr0", (acked.size() > 0) ? acked[0] : '1, 64'h1000);
    check("t1_addr1", (acked.size() > 1) ? acked[1] : '1, 64'h1004);

    // 2: hit without bus traffic
    fetch(64'h1000, 0, "t2");
    check("t2_noreq", {63'd0, bus.mem_req_out}, 64'd0);

    // 3: conflicting tag on the same index evicts
    fetch(64'h1020, 3, "t3a");
    fetch(64'h1020, 0, "t3b");
    fetch(64'h1000, 3, "t3c");

    // 4: slow memory, five cycles per beat
    ack_delay = 4;
    u0 = unstable;
    fetch(64'h2008, 11, "t4");
    check("t4_stable", 64'(unstable - u0), 64'd0);
    ack_delay = 0;
    fetch(64'h2008, 0, "t4_hit");

    // 5: invalidate on the final beat, then on the first beat
    fill_with_inv(64'h3000, 2, "t5a");
    fetch(64'h2008, 3, "t5_other");
    fetch(64'h3000, 3, "t5_same");
    fetch(64'h1000, 3, "t5_old");
    fill_with_inv(64'h4000, 1, "t5b");
    fetch(64'h4000, 3, "t5_drop");

    // 6: reset while waiting on the first beat
    ack_delay = 4;
    bus.instr_address_in = 64'h5000;
    bus.instr_read_in = 1'b1;
    @(posedge clk);
    #1;
    check("t6_req_before", {63'd0, bus.mem_req_out}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_stall", {63'd0, bus.stall_out}, 64'd1);
    check("t6_rst_nop", bus.instr_read_value_out, NOP_WORD);
    @(posedge clk);
    #1;
    check("t6_req_dropped", {63'd0, bus.mem_req_out}, 64'd0);
    check("t6_addr_cleared", bus.mem_addr_out, 64'd0);
    rst_n = 1'b1;
    bus.instr_read_in = 1'b0;
    ack_delay = 0;
    @(posedge clk);
    #1;
    fetch(64'h1000, 3, "t6_miss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
